// File: rtl/mem_arb_pkg.sv
// Shared types for the two-client memory arbiter/controller.
package mem_arb_pkg;

   localparam int N_CLIENTS = 2;

   typedef enum logic [1:0] {
      WAKE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef logic [0:0] client_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, last-grant pointer advances on demand.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       Rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   client_id_t last_q, last_d;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_q == 1'b1) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (advance && (gnt != 2'b00)) begin
         last_d = gnt[1];
      end
   end

   // Reset as "client 1 last" so client 0 wins the first tie.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Two-client controller for a single-port sync-read memory: fill sweep after
// reset, then round-robin one access per cycle with a tagged response.
module mem_arb_ctrl
   import mem_arb_pkg::*;
#(
   parameter int                ADDR_W   = 6,
   parameter int                DATA_W   = 8,
   parameter logic [DATA_W-1:0] FILL_VAL = '0
)(
   input  logic                  clk,
   input  logic                  Rst,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_din,
   input  logic [DATA_W-1:0]     mem_dout,
   output logic                  init_done
);

   localparam int              DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

   state_t                 state_q, state_d;
   logic [ADDR_W:0]        init_cnt_q, init_cnt_d;
   logic [N_CLIENTS-1:0]   tag_q, tag_d;
   logic [N_CLIENTS-1:0]   arb_req;
   logic [N_CLIENTS-1:0]   gnt;
   logic                   in_run;
   client_id_t             sel;

   assign in_run  = (state_q == RUN);
   assign arb_req = in_run ? req_valid : 2'b00;

   rr_arb2 u_arb (
      .clk     (clk),
      .Rst     (Rst),
      .req     (arb_req),
      .advance (|gnt),
      .gnt     (gnt)
   );

   assign sel = gnt[1];

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         WAKE: begin
            state_d    = INIT;
            init_cnt_d = '0;
         end
         INIT: begin
            init_cnt_d = init_cnt_q + CNT_ONE;
            if (init_cnt_q == LAST_IDX) begin
               state_d = RUN;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = WAKE;
      endcase
   end

   // Memory port: fill sweep in INIT, granted client's fields in RUN.
   always_comb begin
      mem_en   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (state_q == INIT) begin
         mem_en   = 1'b1;
         mem_we   = 1'b1;
         mem_addr = init_cnt_q[ADDR_W-1:0];
         mem_din  = FILL_VAL;
      end else if (in_run && (gnt != 2'b00)) begin
         mem_en   = 1'b1;
         mem_we   = sel ? req_we[1] : req_we[0];
         mem_addr = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
         mem_din  = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
   end

   assign tag_d = gnt;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= WAKE;
         init_cnt_q <= '0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         tag_q      <= tag_d;
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = tag_q;
   assign rsp_rdata = (tag_q != 2'b00) ? mem_dout : '0;
   assign init_done = in_run;

endmodule
